wb_master_bridge: RTL
=====================

// Module: wb_master_bridge
// PURPOSE
// Single-outstanding Wishbone master. Converts a simple valid/ready request
// port (core LSU / fetch unit / DMA) into classic Wishbone cycles on a
// wb_bus_t.master interface. Handles ack, err and rty, with bounded retry
// and a no-response timeout. Returns one response per accepted request.
// Pairs with the Wishbone slave memory wrappers on the same bus.
// PARAMETERS
// ADDR_WIDTH  32   request / wb_adr width
// DATA_WIDTH  32   data width; wb_sel width is DATA_WIDTH/8
// MAX_RETRY   3    rty reissues allowed before an error response (0 = none)
// TIMEOUT     256  bus cycles without ack/err/rty before an error response; >=2
// PORTS
// clk          in   1            clock
// rstn_i       in   1            asynchronous active-low reset
// req_valid_i  in   1            request valid
// req_ready_o  out  1            request accepted when valid&ready
// req_addr_i   in   ADDR_WIDTH   byte address
// req_we_i     in   1            1 = write, 0 = read
// req_wdata_i  in   DATA_WIDTH   write data
// req_be_i     in   DATA_WIDTH/8 byte enables
// rsp_valid_o  out  1            one-cycle response pulse
// rsp_rdata_o  out  DATA_WIDTH   read data; held until the next response
// rsp_err_o    out  1            response is an error (err, retries exhausted, timeout)
// busy_o       out  1            a transaction is in flight (state != IDLE)
// wb_bus       wb_bus_t.master   drives wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel;
//                                samples wb_dat_sm, wb_ack, wb_err, wb_rty
// BEHAVIOUR
// - Reset (async, rstn_i=0): state=IDLE. All outputs 0: req_ready_o, rsp_*, busy_o,
//   wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel. Retry and timeout counters 0.
//   Reset mid-transaction drops wb_cyc immediately. No response is produced.
// - All Wishbone outputs come from registers. wb_stb always equals wb_cyc.
// - FSM states: IDLE, BUS, BACKOFF, RESP.
// - IDLE:
//   req_ready_o=1.
//   On valid&ready: latch addr/we/wdata/be, clear retry_cnt and to_cnt, go to BUS.
//   wb_cyc rises in the cycle after acceptance.
// - BUS:
//   wb_cyc=1. Request fields are driven stable. req_ready_o=0.
//   Terminations are sampled each cycle with priority err > ack > rty > timeout.
//   - err: go to RESP with rsp_err=1.
//   - ack: capture wb_dat_sm into rsp_rdata on reads (unchanged on writes); go to
//     RESP with rsp_err=0.
//   - rty, retry_cnt<MAX_RETRY: retry_cnt++, go to BACKOFF.
//   - rty, retry_cnt==MAX_RETRY: go to RESP with rsp_err=1.
//   - Otherwise: to_cnt++. When to_cnt reaches TIMEOUT-1, go to RESP with rsp_err=1.
//   Any exit from BUS deasserts wb_cyc on the next edge. The master never holds
//   cyc past an ack, so a slave that toggles ack while cyc stays high cannot
//   double-complete a transaction.
// - BACKOFF: wb_cyc=0 for exactly one cycle. Clear to_cnt, return to BUS
//   (reissue with identical fields).
// - RESP: rsp_valid_o=1 for one cycle, wb_cyc=0, then go to IDLE.
//   A new request is accepted no earlier than the cycle after RESP.
// - Latency against a slave that acks one cycle after cyc:
//   accept at T -> cyc at T+1 -> ack at T+2 -> rsp_valid at T+3.
//   The next request is accepted at T+4.
// - rsp_rdata_o on an error response is unchanged from its previous value.
// - to_cnt width is $clog2(TIMEOUT); it saturates and never wraps within one attempt.
// - Inputs req_* are ignored outside IDLE. Terminations sampled while wb_cyc=0
//   are ignored.
// TESTING
// 1 Read with 1-cycle ack slave, addr 0x10, slave data 0xDEADBEEF -> cyc high 2 cycles,
//   rsp_valid at T+3, rdata=0xDEADBEEF, err=0.
// 2 Write addr 0x04, data 0x12345678, be 4'hF -> wb_we=1, dat_ms/sel held stable while
//   cyc=1; rsp err=0; read-back via the RAM slave returns 0x12345678.
// 3 Slave asserts rty twice then ack, MAX_RETRY=3 -> two 1-cycle cyc gaps, identical
//   adr on each attempt, single rsp with err=0.
// 4 Slave asserts rty on every attempt, MAX_RETRY=3 -> exactly 4 bus attempts, then
//   rsp err=1; rdata unchanged.
// 5 Silent slave, TIMEOUT=16 -> cyc high exactly 16 cycles, then rsp err=1; ack and err
//   in the same cycle -> err wins.
// 6 rstn_i asserted in BUS -> cyc, rsp_valid, busy 0 immediately; no response; next
//   request completes normally.

Source files
------------

// File: rtl/wb_master_bridge_if.sv
// Wishbone classic bus bundle shared by the master bridge and its slaves.
// Latency: none, plain wires between the two sides.
// Backpressure: carried by the slave's ack/err/rty terminations.
interface wb_bus_t #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) ();
    logic            wb_cyc;
    logic            wb_stb;
    logic            wb_we;
    logic [AW-1:0]   wb_adr;
    logic [DW-1:0]   wb_dat_ms;
    logic [DW/8-1:0] wb_sel;
    logic [DW-1:0]   wb_dat_sm;
    logic            wb_ack;
    logic            wb_err;
    logic            wb_rty;

    modport master (
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
        input  wb_dat_sm, wb_ack, wb_err, wb_rty
    );

    modport slave (
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_ms, wb_sel,
        output wb_dat_sm, wb_ack, wb_err, wb_rty
    );
endinterface

// File: rtl/wb_master_bridge.sv
// Single-outstanding Wishbone master: valid/ready request in, one response pulse out.
// Latency: accept T, cyc T+1, 1-cycle-ack slave -> rsp_valid T+3, next accept T+4.
// Backpressure: req_ready_o only in IDLE; rty backs off one cycle, bounded retry and timeout.
module wb_master_bridge #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [ADDR_WIDTH-1:0]   req_addr_i,
    input  logic                    req_we_i,
    input  logic [DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] req_be_i,
    output logic                    rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    busy_o,
    wb_bus_t.master                 wb_bus
);
    // retry counter must hold 0..MAX_RETRY; keep at least one bit when retry is disabled
    localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic                    r_ready;
    logic                    r_cyc;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_adr;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [DATA_WIDTH/8-1:0] r_sel;
    logic [RW-1:0]           r_retry_cnt;
    logic [TW-1:0]           r_to_cnt;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_err;

    logic w_accept;
    logic w_done;
    logic w_done_err;
    logic w_retry;
    logic w_cap;
    logic w_ack;
    logic w_err;
    logic w_rty;

    // terminations only count while a cycle is actually on the bus
    assign w_ack = wb_bus.wb_ack & r_cyc;
    assign w_err = wb_bus.wb_err & r_cyc;
    assign w_rty = wb_bus.wb_rty & r_cyc;

    // state register
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // next state and per-cycle decisions; priority err > ack > rty > timeout
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done     = 1'b0;
        w_done_err = 1'b0;
        w_retry    = 1'b0;
        w_cap      = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid_i && r_ready) begin
                    w_accept = 1'b1;
                    w_next   = BUS;
                end
            end
            BUS: begin
                if (w_err) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end else if (w_ack) begin
                    w_done = 1'b1;
                    w_cap  = ~r_we;
                end else if (w_rty) begin
                    if (r_retry_cnt < RETRY_LAST) begin
                        w_retry = 1'b1;
                        w_next  = BACKOFF;
                    end else begin
                        w_done     = 1'b1;
                        w_done_err = 1'b1;
                    end
                end else if (r_to_cnt == TO_LAST) begin
                    w_done     = 1'b1;
                    w_done_err = 1'b1;
                end
                if (w_done) w_next = RESP;
            end
            BACKOFF: w_next = BUS;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ready is registered so it stays low through reset and the RESP cycle
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) r_ready <= 1'b0;
        else         r_ready <= (w_next == IDLE);
    end

    // bus-side registers: cyc follows BUS occupancy, fields latched on accept
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_cyc <= 1'b0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_sel <= '0;
        end else begin
            r_cyc <= (w_next == BUS);
            if (w_accept) begin
                r_we  <= req_we_i;
                r_adr <= req_addr_i;
                r_dat <= req_wdata_i;
                r_sel <= req_be_i;
            end
        end
    end

    // retry and no-response counters; to_cnt restarts for every attempt and saturates
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_retry_cnt <= '0;
            r_to_cnt    <= '0;
        end else begin
            if (w_accept)     r_retry_cnt <= '0;
            else if (w_retry) r_retry_cnt <= r_retry_cnt + RW'(1);

            if (w_accept || w_retry || r_state == BACKOFF)
                r_to_cnt <= '0;
            else if (r_state == BUS && !w_done && r_to_cnt != TO_LAST)
                r_to_cnt <= r_to_cnt + TW'(1);
        end
    end

    // response payload; read data only moves on a successful read
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_cap)  r_rdata <= wb_bus.wb_dat_sm;
            if (w_done) r_err   <= w_done_err;
        end
    end

    assign req_ready_o      = r_ready;
    assign rsp_valid_o      = (r_state == RESP);
    assign rsp_err_o        = (r_state == RESP) & r_err;
    assign rsp_rdata_o      = r_rdata;
    assign busy_o           = (r_state != IDLE);
    assign wb_bus.wb_cyc    = r_cyc;
    assign wb_bus.wb_stb    = r_cyc;
    assign wb_bus.wb_we     = r_we;
    assign wb_bus.wb_adr    = r_adr;
    assign wb_bus.wb_dat_ms = r_dat;
    assign wb_bus.wb_sel    = r_sel;
endmodule
